// File: rtl/serial_deserializer.sv
// Serial-to-parallel frame assembler with a one-entry valid/ready output buffer.
// Sticky flags report frames dropped to back-pressure and frames cut short by a new start.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             s_start,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clear_err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_pdata;
  logic             r_pvalid;
  logic             r_ovr;
  logic             r_ferr;

  logic             w_start;
  logic             w_restart;
  logic             w_bit;
  logic             w_last;
  logic             w_free;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;

  assign w_start   = s_valid && s_start;
  assign w_restart = w_start && (r_state == SHIFT);
  assign w_bit     = s_valid && !s_start && (r_state == SHIFT);
  assign w_last    = w_bit && (r_cnt == CW'(WIDTH - 1));
  assign w_free    = !r_pvalid || p_ready;
  assign w_load    = w_last && w_free;
  assign w_drop    = w_last && !w_free;

  // A start bit always begins from an empty register so no stale bits leak in.
  assign w_base = w_start ? '0 : r_sreg;
  assign w_next = MSB_FIRST ? {w_base[WIDTH-2:0], s_data}
                            : {s_data, w_base[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
    end else if (w_start) begin
      r_state <= SHIFT;
      r_cnt   <= CW'(1);
      r_sreg  <= w_next;
    end else if (w_last) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sreg  <= w_next;
    end else if (w_bit) begin
      r_cnt  <= r_cnt + CW'(1);
      r_sreg <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pdata  <= '0;
      r_pvalid <= 1'b0;
    end else if (w_load) begin
      r_pdata  <= w_next;
      r_pvalid <= 1'b1;
    end else if (r_pvalid && p_ready) begin
      r_pvalid <= 1'b0;
    end
  end

  // Set has priority over clear so an event on the clearing edge is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_drop)
        r_ovr <= 1'b1;
      else if (clear_err)
        r_ovr <= 1'b0;
      if (w_restart)
        r_ferr <= 1'b1;
      else if (clear_err)
        r_ferr <= 1'b0;
    end
  end

  assign p_data    = r_pdata;
  assign p_valid   = r_pvalid;
  assign busy      = (r_state == SHIFT);
  assign overrun   = r_ovr;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: vector table plus
// hand sequences for reset, stalls and bit order.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid, s_data, s_start;
  logic       p_ready, clear_err;
  logic [7:0] pd0, pd1;
  logic       pv0, pv1, bs0, bs1, ov0, ov1, fe0, fe1;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_start(s_start), .p_data(pd0), .p_valid(pv0), .p_ready(p_ready),
    .busy(bs0), .overrun(ov0), .frame_err(fe0), .clear_err(clear_err)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_start(s_start), .p_data(pd1), .p_valid(pv1), .p_ready(p_ready),
    .busy(bs1), .overrun(ov1), .frame_err(fe1), .clear_err(clear_err)
  );

  typedef struct {
    logic       v, d, s, r, c;
    logic       pv;
    logic [7:0] pd;
    logic       bsy, ov, fe;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic v, d, s, r, c,
                              input logic pv, input logic [7:0] pd,
                              input logic bsy, ov, fe);
    vec_t e;
    e.v = v; e.d = d; e.s = s; e.r = r; e.c = c;
    e.pv = pv; e.pd = pd; e.bsy = bsy; e.ov = ov; e.fe = fe;
    tv.push_back(e);
  endfunction

  // Eight bits of w, MSB first, start on the first; mid/end expectations given.
  function automatic void add_frame(input logic [7:0] w, input logic r,
                                    input logic mpv, input logic [7:0] mpd,
                                    input logic mov, mfe,
                                    input logic epv, input logic [7:0] epd,
                                    input logic eov, efe);
    for (int i = 7; i >= 0; i--) begin
      if (i > 0)
        add(1'b1, w[i], i == 7, r, 1'b0, mpv, mpd, 1'b1, mov, mfe);
      else
        add(1'b1, w[i], 1'b0, r, 1'b0, epv, epd, 1'b0, eov, efe);
    end
  endfunction

  function automatic logic [11:0] out0();
    return {pv0, pd0, bs0, ov0, fe0};
  endfunction

  function automatic logic [11:0] out1();
    return {pv1, pd1, bs1, ov1, fe1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, d, s);
    s_valid = v;
    s_data  = d;
    s_start = s;
    tick();
  endtask

  logic [7:0] bw;

  initial begin
    reset     = 1'b1;
    s_valid   = 1'($urandom);
    s_data    = 1'($urandom);
    s_start   = 1'($urandom);
    p_ready   = 1'($urandom);
    clear_err = 1'($urandom);
    #2;
    chk("reset_async_dut0", 32'(out0()), 32'h0);
    chk("reset_async_dut1", 32'(out1()), 32'h0);
    tick();
    chk("reset_held", 32'(out0()), 32'h0);
    s_valid = 1'b0; s_data = 1'b0; s_start = 1'b0;
    p_ready = 1'b1; clear_err = 1'b0;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_idle", 32'(out0()), 32'h0);
    end

    // Basic frame B2 with p_ready=1, then a drain cycle
    add_frame(8'hB2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0,
              1'b1, 8'hB2, 1'b0, 1'b0);
    add(0, 0, 0, 1, 0, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0);
    // Back-pressure: B2 loads, 5A dropped
    add_frame(8'hB2, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0,
              1'b1, 8'hB2, 1'b0, 1'b0);
    add_frame(8'h5A, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0,
              1'b1, 8'hB2, 1'b1, 1'b0);
    add(0, 0, 0, 1, 0, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0);
    add(0, 0, 0, 1, 1, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0);
    // Restart after 3 bits, then full 5A frame
    add(1, 1, 1, 1, 0, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b0);
    add(1, 1, 0, 1, 0, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b0);
    add(1, 1, 0, 1, 0, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b0);
    add_frame(8'h5A, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b1,
              1'b1, 8'h5A, 1'b0, 1'b1);
    add(0, 0, 0, 1, 0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    add(0, 0, 0, 1, 1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    // Valid bit without start while idle is ignored
    add(1, 1, 0, 1, 0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    add(0, 0, 0, 1, 0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tv.size(); i++) begin
      p_ready   = tv[i].r;
      clear_err = tv[i].c;
      drive(tv[i].v, tv[i].d, tv[i].s);
      chk($sformatf("vec%0d", i), 32'(out0()),
          32'({tv[i].pv, tv[i].pd, tv[i].bsy, tv[i].ov, tv[i].fe}));
    end
    clear_err = 1'b0;
    p_ready   = 1'b1;

    // Stalled B2 frame; LSB-first instance must produce 4D
    bw = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, bw[i], i == 7);
      if (i > 0) begin
        for (int g = 0; g < (i % 3) + 1; g++)
          drive(1'b0, 1'b0, 1'b0);
        if (i == 4)
          chk("stall_busy", 32'({bs0, pv0}), 32'({1'b1, 1'b0}));
      end
    end
    chk("stall_dut0", 32'(out0()), 32'({1'b1, 8'hB2, 3'b000}));
    chk("lsb_first_dut1", 32'(out1()), 32'({1'b1, 8'h4D, 3'b000}));
    drive(1'b0, 1'b0, 1'b0);

    // Async reset after 4 bits of a frame
    bw = 8'hA5;
    for (int i = 7; i >= 4; i--)
      drive(1'b1, bw[i], i == 7);
    chk("midframe_busy", 32'(bs0), 32'h1);
    #3 reset = 1'b1;
    #1;
    chk("midframe_reset_dut0", 32'(out0()), 32'h0);
    chk("midframe_reset_dut1", 32'(out1()), 32'h0);
    #2 reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    chk("after_reset_idle", 32'(out0()), 32'h0);
    bw = 8'hC3;
    for (int i = 7; i >= 0; i--)
      drive(1'b1, bw[i], i == 7);
    chk("c3_after_reset", 32'(out0()), 32'({1'b1, 8'hC3, 3'b000}));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
